div_ctrl: RTL and testbench
===========================

# div_ctrl

CPU-side initiator for the iterative `divider`. It accepts DIV/DIVU requests from the EX stage and converts signed operands to magnitudes. It drives the divider's `ready_i`/operand inputs, waits for `valid_o`, applies sign correction, and writes HI (remainder) / LO (quotient). While a division is outstanding it stalls the pipeline and supports flush-on-exception.

## Interface
Parameters:
- `DIV0_LO`, 32'hFFFF_FFFF: LO value written on divide-by-zero.

Ports:
- `clk` in 1: clock.
- `reset_n` in 1: asynchronous, active-low reset.
- `start_i` in 1: one-cycle DIV/DIVU request from EX.
- `signed_i` in 1: 1 = DIV (two's complement), 0 = DIVU.
- `op_a_i` in 32: dividend (rs).
- `op_b_i` in 32: divisor (rt).
- `flush_i` in 1: cancel the outstanding request (exception/ERET).
- `busy_o` out 1: stall request, equal to `state != IDLE`.
- `div_ready_o` out 1: start strobe to `divider.ready_i`.
- `div_dividend_o` out 32: magnitude to `divider.dividend_i`.
- `div_divisor_o` out 32: magnitude to `divider.divisor_i`.
- `div_valid_i` in 1: `divider.valid_o`.
- `div_quotient_i` in 32: `divider.quotient_o`.
- `div_remainder_i` in 32: `divider.remainder_o`.
- `hilo_we_o` out 1: one-cycle write enable for HI and LO.
- `hi_o` out 32: remainder.
- `lo_o` out 32: quotient.

## Operation
- States:
  - IDLE: ready for a new request.
  - ISSUE: start strobe to the divider.
  - WAIT: waiting for the divider result.
  - WB: writeback cycle.
  - DRAIN: discarding the result of a flushed request.
- IDLE:
  - On `start_i & !flush_i`, register `|a|`, `|b|`, `neg_q = signed & (a[31]^b[31])`, `neg_r = signed & a[31]`.
  - Magnitudes pass through unchanged when `signed_i=0`.
  - If `op_b_i == 0`: go to WB with `hi = op_a_i` and `lo = DIV0_LO`; the divider is not issued.
  - Otherwise go to ISSUE.
- ISSUE:
  - `div_ready_o=1` for exactly this cycle; operands are valid.
  - Next state is WAIT, or DRAIN if `flush_i`.
- WAIT:
  - Operand outputs are held stable.
  - On `div_valid_i`: capture `q = neg_q ? -quotient : quotient` and `r = neg_r ? -remainder : remainder` into `lo`/`hi`, then go to WB.
  - If `flush_i` arrives in the same cycle as `div_valid_i`, discard and go to IDLE.
  - If `flush_i` arrives without `div_valid_i`, go to DRAIN.
- WB:
  - `hilo_we_o = !flush_i`.
  - Always returns to IDLE.
- DRAIN:
  - Wait for `div_valid_i`, discard the result, return to IDLE. No HI/LO write.
  - `busy_o` stays high so that no second request overlaps the divider.
- Arithmetic:
  - Negation is 32-bit two's complement with wrap.
  - -2^31 / -1 gives q = 0x8000_0000, r = 0.
  - -2^31 / 1 gives q = 0x8000_0000, r = 0.
- `start_i` while busy is ignored. The pipeline must not assert it while stalled.

## Timing
- Reset values: state IDLE; `busy_o`, `div_ready_o`, `hilo_we_o` = 0; `div_dividend_o`, `div_divisor_o`, `hi_o`, `lo_o` = 0.
- Cycle sequence for a divider latency of L cycles from `ready` to `valid`:
  - Start accepted at cycle 0.
  - ISSUE in cycle 1.
  - `div_valid_i` at cycle 1+L.
  - WB (`hilo_we_o`) at cycle 2+L.
  - IDLE at cycle 3+L.
- Divide-by-zero: start at cycle 0, WB at cycle 1, IDLE at cycle 2.
- All outputs are registered.
- `hi_o`/`lo_o` are valid while `hilo_we_o` is high and hold their value until the next capture.
- Asynchronous reset mid-operation returns to IDLE immediately. The divider is reset by the same `reset_n`, so no drain is needed.

## Structure
- Shared package `div_pkg`:
  - State enumeration (3-bit).
  - `DIV0_LO` default.
  - HI/LO field widths, if reused by the multiplier controller.
- Sub-module `div_sign_fix`: combinational. Takes the magnitude and negate flag, returns the 32-bit result. It is instantiated twice, for the quotient and the remainder; the operand abs paths reuse the same function.
- Estimated size: about 180 lines.

## Test plan
Bench uses a behavioural divider stub with L=33 and `$random` operands, checked against the Verilog `/` and `%` operators, including signed variants.
- DIVU: 100 / 7, `signed_i=0` -> `div_ready_o` pulse at cycle 1; `hilo_we_o` at cycle 35 with `lo_o=14`, `hi_o=2`; `busy_o` high for cycles 1–35.
- DIV: -7 / 2 -> lo=0xFFFF_FFFD (-3), hi=0xFFFF_FFFF (-1). 7 / -2 -> lo=-3, hi=1.
- DIV: 0x8000_0000 / 0xFFFF_FFFF -> lo=0x8000_0000, hi=0; no X values on any output.
- Divide by zero: 5 / 0 -> no `div_ready_o`; `hilo_we_o` at cycle 1 with hi=5, lo=0xFFFF_FFFF.
- `flush_i` at cycle 10 during WAIT -> DRAIN, `busy_o` stays high until the cycle after `div_valid_i` (cycle 34); no `hilo_we_o`. A `start_i` at cycle 35 issues normally.
- Flush in the same cycle as `div_valid_i` -> IDLE on the next cycle with no write. Reset asserted at cycle 20 -> all outputs 0 asynchronously.

Source files
------------

// File: rtl/div_pkg.sv
// Shared types and constants for the HI/LO divide controller.
// HI/LO widths are kept here so the multiply controller can reuse them.
package div_pkg;

   localparam int DATA_W = 32;
   localparam int HI_W   = DATA_W;
   localparam int LO_W   = DATA_W;

   localparam logic [LO_W-1:0] DIV0_LO_DEFAULT = 32'hFFFF_FFFF;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_ISSUE = 3'd1,
      ST_WAIT  = 3'd2,
      ST_WB    = 3'd3,
      ST_DRAIN = 3'd4
   } div_state_e;

   // Two's complement negate with wrap when neg is set, pass-through otherwise.
   function automatic logic [DATA_W-1:0] signFix(input logic [DATA_W-1:0] val,
                                                 input logic              neg);
      return neg ? ((~val) + DATA_W'(1)) : val;
   endfunction

endpackage

// File: rtl/div_sign_fix.sv
// Combinational sign correction: returns the magnitude, or its two's complement
// negation when i_neg is set.
module div_sign_fix
   import div_pkg::*;
(
   input  logic [DATA_W-1:0] i_mag,
   input  logic              i_neg,
   output logic [DATA_W-1:0] o_result
);

   assign o_result = signFix(i_mag, i_neg);

endmodule

// File: rtl/div_ctrl.sv
// CPU-side controller for the iterative divider: converts DIV/DIVU operands to
// magnitudes, sequences the divider handshake, and writes sign-corrected HI/LO.
module div_ctrl
   import div_pkg::*;
#(
   parameter logic [LO_W-1:0] DIV0_LO = DIV0_LO_DEFAULT
)(
   input  logic              clk,
   input  logic              reset_n,
   input  logic              start_i,
   input  logic              signed_i,
   input  logic [DATA_W-1:0] op_a_i,
   input  logic [DATA_W-1:0] op_b_i,
   input  logic              flush_i,
   output logic              busy_o,
   output logic              div_ready_o,
   output logic [DATA_W-1:0] div_dividend_o,
   output logic [DATA_W-1:0] div_divisor_o,
   input  logic              div_valid_i,
   input  logic [DATA_W-1:0] div_quotient_i,
   input  logic [DATA_W-1:0] div_remainder_i,
   output logic              hilo_we_o,
   output logic [HI_W-1:0]   hi_o,
   output logic [LO_W-1:0]   lo_o
);

   div_state_e        r_state;
   logic              r_busy;
   logic              r_ready;
   logic              r_we;
   logic              r_negQ;
   logic              r_negR;
   logic [DATA_W-1:0] r_dividend;
   logic [DATA_W-1:0] r_divisor;
   logic [HI_W-1:0]   r_hi;
   logic [LO_W-1:0]   r_lo;

   div_state_e        w_nextState;
   logic              w_accept;
   logic              w_capture;
   logic              w_divZero;
   logic              w_negA;
   logic              w_negB;
   logic [DATA_W-1:0] w_absA;
   logic [DATA_W-1:0] w_absB;
   logic [DATA_W-1:0] w_quotFix;
   logic [DATA_W-1:0] w_remFix;

   assign w_negA    = signed_i & op_a_i[DATA_W-1];
   assign w_negB    = signed_i & op_b_i[DATA_W-1];
   assign w_absA    = signFix(op_a_i, w_negA);
   assign w_absB    = signFix(op_b_i, w_negB);
   assign w_divZero = (op_b_i == '0);

   div_sign_fix u_quotFix (
      .i_mag    (div_quotient_i),
      .i_neg    (r_negQ),
      .o_result (w_quotFix)
   );

   div_sign_fix u_remFix (
      .i_mag    (div_remainder_i),
      .i_neg    (r_negR),
      .o_result (w_remFix)
   );

   always_comb begin
      w_nextState = r_state;
      w_accept    = 1'b0;
      w_capture   = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (start_i && !flush_i) begin
               w_accept    = 1'b1;
               w_nextState = w_divZero ? ST_WB : ST_ISSUE;
            end
         end
         ST_ISSUE: begin
            w_nextState = flush_i ? ST_DRAIN : ST_WAIT;
         end
         ST_WAIT: begin
            // A flush coinciding with the result means the divider is already done.
            if (div_valid_i && flush_i) begin
               w_nextState = ST_IDLE;
            end else if (div_valid_i) begin
               w_capture   = 1'b1;
               w_nextState = ST_WB;
            end else if (flush_i) begin
               w_nextState = ST_DRAIN;
            end
         end
         ST_WB: begin
            w_nextState = ST_IDLE;
         end
         ST_DRAIN: begin
            if (div_valid_i) begin
               w_nextState = ST_IDLE;
            end
         end
         default: begin
            w_nextState = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_state    <= ST_IDLE;
         r_busy     <= 1'b0;
         r_ready    <= 1'b0;
         r_we       <= 1'b0;
         r_negQ     <= 1'b0;
         r_negR     <= 1'b0;
         r_dividend <= '0;
         r_divisor  <= '0;
         r_hi       <= '0;
         r_lo       <= '0;
      end else begin
         r_state <= w_nextState;
         r_busy  <= (w_nextState != ST_IDLE);
         r_ready <= (w_nextState == ST_ISSUE);
         r_we    <= (w_nextState == ST_WB);
         if (w_accept) begin
            r_dividend <= w_absA;
            r_divisor  <= w_absB;
            r_negQ     <= w_negA ^ w_negB;
            r_negR     <= w_negA;
            // Divide-by-zero bypasses the divider and writes back directly.
            if (w_divZero) begin
               r_hi <= op_a_i;
               r_lo <= DIV0_LO;
            end
         end
         if (w_capture) begin
            r_hi <= w_remFix;
            r_lo <= w_quotFix;
         end
      end
   end

   assign busy_o         = r_busy;
   assign div_ready_o    = r_ready;
   assign div_dividend_o = r_dividend;
   assign div_divisor_o  = r_divisor;
   assign hilo_we_o      = r_we & ~flush_i;
   assign hi_o           = r_hi;
   assign lo_o           = r_lo;

endmodule

// File: tb/tb_div_ctrl.sv
// Testbench for div_ctrl: divider stub with fixed latency, timeline-based
// reference model checked every cycle, plus literal directed expectations.
module tb_div_ctrl;
   import div_pkg::*;

   localparam int L = 33;

   logic        clk       = 1'b0;
   logic        reset_n   = 1'b0;
   logic        start_i   = 1'b0;
   logic        signed_i  = 1'b0;
   logic        flush_i   = 1'b0;
   logic [31:0] op_a_i    = '0;
   logic [31:0] op_b_i    = '0;
   logic        busy_o;
   logic        div_ready_o;
   logic [31:0] div_dividend_o;
   logic [31:0] div_divisor_o;
   logic        div_valid_i     = 1'b0;
   logic [31:0] div_quotient_i  = '0;
   logic [31:0] div_remainder_i = '0;
   logic        hilo_we_o;
   logic [31:0] hi_o;
   logic [31:0] lo_o;

   int total   = 0;
   int bad     = 0;
   bit checkEn = 1'b0;

   always #5 clk = ~clk;

   div_ctrl dut (
      .clk             (clk),
      .reset_n         (reset_n),
      .start_i         (start_i),
      .signed_i        (signed_i),
      .op_a_i          (op_a_i),
      .op_b_i          (op_b_i),
      .flush_i         (flush_i),
      .busy_o          (busy_o),
      .div_ready_o     (div_ready_o),
      .div_dividend_o  (div_dividend_o),
      .div_divisor_o   (div_divisor_o),
      .div_valid_i     (div_valid_i),
      .div_quotient_i  (div_quotient_i),
      .div_remainder_i (div_remainder_i),
      .hilo_we_o       (hilo_we_o),
      .hi_o            (hi_o),
      .lo_o            (lo_o)
   );

   // Behavioural divider: valid pulses L cycles after the ready strobe.
   int          stubCnt = 0;
   logic [31:0] stubA   = '0;
   logic [31:0] stubB   = 32'd1;
   always @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         stubCnt     = 0;
         div_valid_i <= 1'b0;
      end else begin
         div_valid_i <= 1'b0;
         if (div_ready_o) begin
            stubA   = div_dividend_o;
            stubB   = div_divisor_o;
            stubCnt = L - 1;
         end else if (stubCnt > 0) begin
            stubCnt = stubCnt - 1;
            if (stubCnt == 0) begin
               div_valid_i     <= 1'b1;
               div_quotient_i  <= stubA / stubB;
               div_remainder_i <= stubA % stubB;
            end
         end
      end
   end

   // Reference result straight from the language's division operators.
   task automatic refDiv(input bit sg, input logic [31:0] a, input logic [31:0] b,
                         output logic [31:0] q, output logic [31:0] r);
      int sa;
      int sb;
      if (b == 32'd0) begin
         q = 32'hFFFF_FFFF;
         r = a;
      end else if (sg) begin
         if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
            q = 32'h8000_0000;
            r = 32'd0;
         end else begin
            sa = $signed(a);
            sb = $signed(b);
            q  = 32'(sa / sb);
            r  = 32'(sa % sb);
         end
      end else begin
         q = a / b;
         r = a % b;
      end
   endtask

   function automatic logic [31:0] magOf(input bit sg, input logic [31:0] v);
      return (sg && v[31]) ? 32'(0 - v) : v;
   endfunction

   // Timeline model: each accepted request fixes the cycles of issue, result,
   // writeback and return to idle; a flush before the result cancels writeback.
   int          cyc     = 0;
   bit          mActive = 1'b0;
   int          mStart  = 0;
   int          mIssue  = -1;
   int          mValid  = -1;
   int          mWb     = -1;
   int          mEnd    = 0;
   bit          pPending = 1'b0;
   logic [31:0] pHi = '0, pLo = '0;
   logic [31:0] eDividend = '0, eDivisor = '0, eHi = '0, eLo = '0;

   function automatic bit busyAt(input int c);
      return mActive && (c > mStart) && (c < mEnd);
   endfunction

   always @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         mActive   = 1'b0;
         mIssue    = -1;
         mValid    = -1;
         mWb       = -1;
         pPending  = 1'b0;
         eDividend = '0;
         eDivisor  = '0;
         eHi       = '0;
         eLo       = '0;
      end else begin
         if (busyAt(cyc)) begin
            if (flush_i && pPending && mIssue >= 0 && cyc >= mIssue && cyc <= mValid) begin
               pPending = 1'b0;
               mWb      = -1;
               mEnd     = mValid + 1;
            end
         end else if (start_i && !flush_i) begin
            mActive   = 1'b1;
            mStart    = cyc;
            eDividend = magOf(signed_i, op_a_i);
            eDivisor  = magOf(signed_i, op_b_i);
            refDiv(signed_i, op_a_i, op_b_i, pLo, pHi);
            pPending  = 1'b1;
            if (op_b_i == 32'd0) begin
               mIssue = -1;
               mValid = -1;
               mWb    = cyc + 1;
               mEnd   = cyc + 2;
            end else begin
               mIssue = cyc + 1;
               mValid = cyc + 1 + L;
               mWb    = cyc + 2 + L;
               mEnd   = cyc + 3 + L;
            end
         end
         cyc = cyc + 1;
         if (pPending && cyc == mWb) begin
            eHi      = pHi;
            eLo      = pLo;
            pPending = 1'b0;
         end
      end
   end

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("[TB] FAIL %s at cycle %0d: got %h, expected %h", name, cyc, act, exp);
      end
   endtask

   always @(negedge clk) begin
      if (checkEn && reset_n) begin
         checkOutput("busy",     32'(busy_o),      32'(busyAt(cyc)));
         checkOutput("ready",    32'(div_ready_o), 32'(cyc == mIssue));
         checkOutput("hilo_we",  32'(hilo_we_o),   32'((cyc == mWb) && !flush_i));
         checkOutput("dividend", div_dividend_o,   eDividend);
         checkOutput("divisor",  div_divisor_o,    eDivisor);
         checkOutput("hi",       hi_o,             eHi);
         checkOutput("lo",       lo_o,             eLo);
      end
   end

   // One call drives the inputs for exactly one cycle.
   task automatic applyStimulus(input bit st, input bit sg, input logic [31:0] a,
                                input logic [31:0] b, input bit fl);
      @(posedge clk);
      #1;
      start_i  = st;
      signed_i = sg;
      op_a_i   = a;
      op_b_i   = b;
      flush_i  = fl;
   endtask

   task automatic idleCycles(input int n);
      for (int i = 0; i < n; i++) applyStimulus(1'b0, 1'($urandom), $urandom, $urandom, 1'b0);
   endtask

   task automatic directedDiv(input string name, input bit sg, input logic [31:0] a,
                              input logic [31:0] b, input logic [31:0] expHi,
                              input logic [31:0] expLo);
      applyStimulus(1'b1, sg, a, b, 1'b0);
      idleCycles(L + 2);
      @(negedge clk);
      checkOutput({name, "_we"}, 32'(hilo_we_o), 32'd1);
      checkOutput({name, "_hi"}, hi_o, expHi);
      checkOutput({name, "_lo"}, lo_o, expLo);
      idleCycles(1);
   endtask

   function automatic logic [31:0] randOp();
      case ($urandom % 6)
         0:       return 32'h8000_0000;
         1:       return 32'hFFFF_FFFF;
         2:       return 32'd1;
         3:       return $urandom % 64;
         default: return $urandom;
      endcase
   endfunction

   initial begin
      #12;
      checkOutput("rst_busy",     32'(busy_o),      32'd0);
      checkOutput("rst_ready",    32'(div_ready_o), 32'd0);
      checkOutput("rst_we",       32'(hilo_we_o),   32'd0);
      checkOutput("rst_dividend", div_dividend_o,   32'd0);
      checkOutput("rst_hi",       hi_o,             32'd0);
      checkOutput("rst_lo",       lo_o,             32'd0);
      @(negedge clk);
      reset_n = 1'b1;
      checkEn = 1'b1;
      idleCycles(2);

      // DIVU 100/7 with cycle-exact handshake checks
      applyStimulus(1'b1, 1'b0, 32'd100, 32'd7, 1'b0);
      @(negedge clk);
      checkOutput("divu_busy_c0", 32'(busy_o), 32'd0);
      applyStimulus(1'b0, 1'b0, 32'd0, 32'd0, 1'b0);
      @(negedge clk);
      checkOutput("divu_ready_c1", 32'(div_ready_o), 32'd1);
      checkOutput("divu_busy_c1",  32'(busy_o),      32'd1);
      idleCycles(34);
      @(negedge clk);
      checkOutput("divu_we_c35", 32'(hilo_we_o), 32'd1);
      checkOutput("divu_lo",     lo_o,           32'd14);
      checkOutput("divu_hi",     hi_o,           32'd2);
      idleCycles(1);
      @(negedge clk);
      checkOutput("divu_busy_c36", 32'(busy_o), 32'd0);

      directedDiv("neg7_2",  1'b1, 32'hFFFF_FFF9, 32'd2,        32'hFFFF_FFFF, 32'hFFFF_FFFD);
      directedDiv("7_neg2",  1'b1, 32'd7,         32'hFFFF_FFFE, 32'd1,        32'hFFFF_FFFD);
      directedDiv("min_m1",  1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0,        32'h8000_0000);
      directedDiv("min_1",   1'b1, 32'h8000_0000, 32'd1,         32'd0,        32'h8000_0000);
      directedDiv("divu_big",1'b0, 32'hFFFF_FFF9, 32'd2,         32'd1,        32'h7FFF_FFFC);

      // Divide by zero: no divider issue, writeback on the next cycle
      applyStimulus(1'b1, 1'b0, 32'd5, 32'd0, 1'b0);
      applyStimulus(1'b0, 1'b0, 32'd0, 32'd0, 1'b0);
      @(negedge clk);
      checkOutput("dz_ready", 32'(div_ready_o), 32'd0);
      checkOutput("dz_we",    32'(hilo_we_o),   32'd1);
      checkOutput("dz_hi",    hi_o,             32'd5);
      checkOutput("dz_lo",    lo_o,             32'hFFFF_FFFF);
      idleCycles(1);
      @(negedge clk);
      checkOutput("dz_busy_c2", 32'(busy_o), 32'd0);
      applyStimulus(1'b1, 1'b1, 32'hFFFF_FFF7, 32'd0, 1'b0);
      applyStimulus(1'b0, 1'b0, 32'd0, 32'd0, 1'b0);
      @(negedge clk);
      checkOutput("dz_signed_hi", hi_o, 32'hFFFF_FFF7);
      idleCycles(2);

      // Flush during WAIT: drain until the divider result, then accept a new start
      applyStimulus(1'b1, 1'b0, 32'd1000, 32'd3, 1'b0);
      idleCycles(9);
      applyStimulus(1'b0, 1'b0, 32'd0, 32'd0, 1'b1);
      idleCycles(24);
      @(negedge clk);
      checkOutput("drain_busy_c34", 32'(busy_o), 32'd1);
      applyStimulus(1'b1, 1'b0, 32'd50, 32'd5, 1'b0);
      @(negedge clk);
      checkOutput("drain_busy_c35", 32'(busy_o), 32'd0);
      applyStimulus(1'b0, 1'b0, 32'd0, 32'd0, 1'b0);
      @(negedge clk);
      checkOutput("drain_reissue_ready", 32'(div_ready_o), 32'd1);
      idleCycles(34);
      @(negedge clk);
      checkOutput("drain_reissue_lo", lo_o, 32'd10);
      checkOutput("drain_reissue_we", 32'(hilo_we_o), 32'd1);
      idleCycles(2);

      // Flush in the same cycle as the divider result
      applyStimulus(1'b1, 1'b1, 32'hFFFF_FFEC, 32'd3, 1'b0);
      idleCycles(L);
      applyStimulus(1'b0, 1'b0, 32'd0, 32'd0, 1'b1);
      applyStimulus(1'b0, 1'b0, 32'd0, 32'd0, 1'b0);
      @(negedge clk);
      checkOutput("flushv_busy", 32'(busy_o),    32'd0);
      checkOutput("flushv_we",   32'(hilo_we_o), 32'd0);
      checkOutput("flushv_lo",   lo_o,           32'd10);
      idleCycles(2);

      // Asynchronous reset in the middle of a division
      applyStimulus(1'b1, 1'b0, 32'd77, 32'd4, 1'b0);
      idleCycles(20);
      #2;
      reset_n = 1'b0;
      #1;
      checkOutput("arst_busy",     32'(busy_o),      32'd0);
      checkOutput("arst_ready",    32'(div_ready_o), 32'd0);
      checkOutput("arst_we",       32'(hilo_we_o),   32'd0);
      checkOutput("arst_dividend", div_dividend_o,   32'd0);
      checkOutput("arst_divisor",  div_divisor_o,    32'd0);
      checkOutput("arst_hi",       hi_o,             32'd0);
      checkOutput("arst_lo",       lo_o,             32'd0);
      @(negedge clk);
      reset_n = 1'b1;
      idleCycles(2);

      // Random traffic, including starts while busy and stray flushes
      for (int n = 0; n < 4000; n++) begin
         logic [31:0] ra;
         logic [31:0] rb;
         ra = randOp();
         rb = (($urandom % 8) == 0) ? 32'd0 : randOp();
         applyStimulus(1'(($urandom % 6) == 0), 1'($urandom), ra, rb, 1'(($urandom % 30) == 0));
      end
      idleCycles(L + 5);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
